// File: rtl/cdc_in_arbiter.sv
// Two-source byte-stream arbiter for the usb_cdc IN channel. It grants per message (burst limit, EOP byte or idle timeout).
// Output is a registered single-entry stage. From IDLE it takes 2 cycles from valid to in_valid_o, and the granted ready tracks the free slot.
module cdc_in_arbiter #(
    parameter int unsigned BURST_MAX = 8,
    parameter bit          EOP_EN    = 1'b1,
    parameter logic [7:0]  EOP_BYTE  = 8'h0A,
    parameter int unsigned IDLE_MAX  = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] a_data_i,
    input  logic       a_valid_i,
    output logic       a_ready_o,
    input  logic [7:0] b_data_i,
    input  logic       b_valid_i,
    output logic       b_ready_o,
    output logic [7:0] in_data_o,
    output logic       in_valid_o,
    input  logic       in_ready_i,
    output logic [1:0] grant_o
);
    typedef enum logic [1:0] {S_IDLE, S_GNT_A, S_GNT_B} state_t;

    localparam logic [7:0] LP_BURST = 8'(BURST_MAX);
    localparam logic [7:0] LP_IDLE  = 8'(IDLE_MAX);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last;         // 1: B was the last source released
    logic [7:0] r_burst_cnt;
    logic [7:0] r_idle_cnt;
    logic [7:0] r_in_data;
    logic       r_in_valid;

    logic       w_slot_free;
    logic       w_granted;
    logic       w_gnt_vld;
    logic [7:0] w_gnt_dat;
    logic       w_accept;
    logic [7:0] w_idle_inc;
    logic       w_rel_burst;
    logic       w_rel_eop;
    logic       w_rel_idle;
    logic       w_release;

    assign w_slot_free = ~r_in_valid | in_ready_i;
    assign w_granted   = (r_state == S_GNT_A) || (r_state == S_GNT_B);
    assign w_gnt_vld   = (r_state == S_GNT_A) ? a_valid_i :
                         (r_state == S_GNT_B) ? b_valid_i : 1'b0;
    assign w_gnt_dat   = (r_state == S_GNT_B) ? b_data_i : a_data_i;
    assign w_accept    = w_granted & w_gnt_vld & w_slot_free;

    assign w_idle_inc  = (r_idle_cnt == 8'hFF) ? r_idle_cnt : r_idle_cnt + 8'd1;
    assign w_rel_burst = w_accept & ((r_burst_cnt + 8'd1) == LP_BURST);
    assign w_rel_eop   = w_accept & EOP_EN & (w_gnt_dat == EOP_BYTE);
    assign w_rel_idle  = w_granted & ~w_gnt_vld & (w_idle_inc >= LP_IDLE);
    assign w_release   = w_rel_burst | w_rel_eop | w_rel_idle;

    assign a_ready_o  = (r_state == S_GNT_A) & w_slot_free;
    assign b_ready_o  = (r_state == S_GNT_B) & w_slot_free;
    assign grant_o    = {r_state == S_GNT_B, r_state == S_GNT_A};
    assign in_data_o  = r_in_data;
    assign in_valid_o = r_in_valid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                // On a tie, the source that was not served last wins.
                if (a_valid_i && (!b_valid_i || r_last))
                    w_state_nxt = S_GNT_A;
                else if (b_valid_i)
                    w_state_nxt = S_GNT_B;
            end
            S_GNT_A, S_GNT_B: begin
                if (w_release)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_burst_cnt <= 8'd0;
            r_idle_cnt  <= 8'd0;
            r_in_data   <= 8'h00;
            r_in_valid  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_release) begin
                r_last      <= (r_state == S_GNT_B);
                r_burst_cnt <= 8'd0;
                r_idle_cnt  <= 8'd0;
            end else if (w_accept) begin
                r_burst_cnt <= r_burst_cnt + 8'd1;
                r_idle_cnt  <= 8'd0;
            end else if (w_granted && !w_gnt_vld) begin
                r_idle_cnt <= w_idle_inc;
            end
            // The final byte of a grant still lands in the output stage.
            if (w_accept) begin
                r_in_data  <= w_gnt_dat;
                r_in_valid <= 1'b1;
            end else if (r_in_valid && in_ready_i) begin
                r_in_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cdc_in_arbiter.sv
// Bench for cdc_in_arbiter: a per-cycle vector table for the first message, then scoreboard-driven multi-source sequences.
module tb_cdc_in_arbiter;
    localparam int IDLE_MAX  = 16;
    localparam int BURST_MAX = 8;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] a_data_i, b_data_i, in_data_o;
    logic       a_valid_i, a_ready_o, b_valid_i, b_ready_o;
    logic       in_valid_o, in_ready_i;
    logic [1:0] grant_o;

    always #5 clk_i = ~clk_i;

    cdc_in_arbiter #(
        .BURST_MAX(BURST_MAX), .EOP_EN(1'b1), .EOP_BYTE(8'h0A), .IDLE_MAX(IDLE_MAX)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_data_i(a_data_i), .a_valid_i(a_valid_i), .a_ready_o(a_ready_o),
        .b_data_i(b_data_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
        .grant_o(grant_o)
    );

    typedef struct {
        logic       a_vld;
        logic [7:0] a_dat;
        logic [1:0] g;
        logic       a_rdy;
        logic       ov;
        logic [7:0] od;
    } vec_t;
    vec_t tbl[22];

    logic [7:0] a_src[$];
    logic [7:0] b_src[$];
    logic [7:0] sb_q[$];

    int checks = 0;
    int errors = 0;
    int cyc, a_acc, cnt_in, cnt_out, last_a_cyc, rel_cyc, b_first_cyc, b_a_acc;
    bit a_en, b_en, rdy_en, sb_auto, b_seen, rel_seen;
    logic [1:0] prev_grant, b_prev_grant;
    logic [7:0] held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        a_data_i = 8'h00; b_data_i = 8'h00;
        in_ready_i = 1'b1;
        a_en = 0; b_en = 0; rdy_en = 1; sb_auto = 1;
        a_src.delete(); b_src.delete(); sb_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        #1;
        cyc = 0; a_acc = 0; cnt_in = 0; cnt_out = 0;
        last_a_cyc = -1; rel_cyc = -1; b_first_cyc = -1; b_a_acc = -1;
        b_seen = 0; rel_seen = 0; prev_grant = 2'b00; b_prev_grant = 2'b11;
        chk("rst_in_valid", in_valid_o, 1'b0);
        chk("rst_in_data", in_data_o, 8'h00);
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_a_ready", a_ready_o, 1'b0);
        chk("rst_b_ready", b_ready_o, 1'b0);
    endtask

    // One cycle: drive sources after the edge, then observe handshakes due at the next edge.
    task automatic step();
        @(posedge clk_i);
        #1;
        a_valid_i = a_en && (a_src.size() > 0);
        a_data_i  = (a_src.size() > 0) ? a_src[0] : 8'h00;
        b_valid_i = b_en && (b_src.size() > 0);
        b_data_i  = (b_src.size() > 0) ? b_src[0] : 8'h00;
        in_ready_i = rdy_en;
        #1;
        if (a_valid_i && a_ready_o) begin
            if (sb_auto) sb_q.push_back(a_data_i);
            void'(a_src.pop_front());
            a_acc++; cnt_in++; last_a_cyc = cyc;
        end
        if (b_valid_i && b_ready_o) begin
            if (sb_auto) sb_q.push_back(b_data_i);
            void'(b_src.pop_front());
            cnt_in++;
        end
        if (in_valid_o && in_ready_i) begin
            cnt_out++;
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_extra_byte: got %0h want none", in_data_o);
            end else begin
                chk("sb_byte", in_data_o, sb_q.pop_front());
            end
        end
        if (grant_o == 2'b10 && !b_seen) begin
            b_seen = 1; b_first_cyc = cyc; b_prev_grant = prev_grant; b_a_acc = a_acc;
        end
        if (prev_grant == 2'b01 && grant_o == 2'b00 && !rel_seen) begin
            rel_seen = 1; rel_cyc = cyc;
        end
        prev_grant = grant_o;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Test 1: A sends 11 22 33, then goes idle until the timeout releases the grant.
        tbl[0] = '{1'b1, 8'h11, 2'b00, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 8'h11, 2'b01, 1'b1, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 8'h22, 2'b01, 1'b1, 1'b1, 8'h11};
        tbl[3] = '{1'b1, 8'h33, 2'b01, 1'b1, 1'b1, 8'h22};
        tbl[4] = '{1'b0, 8'h00, 2'b01, 1'b1, 1'b1, 8'h33};
        for (int i = 5; i < 22; i++)
            tbl[i] = '{1'b0, 8'h00, (i < 20) ? 2'b01 : 2'b00, (i < 20) ? 1'b1 : 1'b0, 1'b0, 8'h33};

        do_reset();
        for (int i = 0; i < 22; i++) begin
            @(posedge clk_i);
            #1;
            a_valid_i = tbl[i].a_vld; a_data_i = tbl[i].a_dat;
            b_valid_i = 1'b0; in_ready_i = 1'b1;
            #1;
            chk($sformatf("t1_grant_c%0d", i), grant_o, tbl[i].g);
            chk($sformatf("t1_a_ready_c%0d", i), a_ready_o, tbl[i].a_rdy);
            chk($sformatf("t1_in_valid_c%0d", i), in_valid_o, tbl[i].ov);
            chk($sformatf("t1_in_data_c%0d", i), in_data_o, tbl[i].od);
        end

        // Test 2: both sources send EOP-terminated messages; output must alternate.
        do_reset();
        sb_auto = 0;
        for (int m = 0; m < 3; m++) begin
            a_src.push_back(8'hA1); a_src.push_back(8'h0A);
            b_src.push_back(8'hB1); b_src.push_back(8'h0A);
        end
        for (int m = 0; m < 3; m++) begin
            sb_q.push_back(8'hA1); sb_q.push_back(8'h0A);
            sb_q.push_back(8'hB1); sb_q.push_back(8'h0A);
        end
        a_en = 1; b_en = 1;
        repeat (50) step();
        chk("t2_sb_drained", sb_q.size(), 0);
        chk("t2_out_count", cnt_out, 12);

        // Test 3: A streams 20 non-EOP bytes while B waits with one message.
        do_reset();
        sb_auto = 0;
        for (int i = 0; i < 20; i++) a_src.push_back(8'(8'h40 + i));
        b_src.push_back(8'hB0); b_src.push_back(8'hB1); b_src.push_back(8'h0A);
        for (int i = 0; i < 8; i++) sb_q.push_back(8'(8'h40 + i));
        sb_q.push_back(8'hB0); sb_q.push_back(8'hB1); sb_q.push_back(8'h0A);
        for (int i = 8; i < 20; i++) sb_q.push_back(8'(8'h40 + i));
        a_en = 1; b_en = 1;
        repeat (60) step();
        chk("t3_b_granted", b_seen, 1'b1);
        chk("t3_a_bytes_before_b", b_a_acc, BURST_MAX);
        chk("t3_bubble_before_b", b_prev_grant, 2'b00);
        chk("t3_sb_drained", sb_q.size(), 0);

        // Test 4: output stalled for 5 cycles mid-burst.
        do_reset();
        for (int i = 0; i < 10; i++) a_src.push_back(8'(8'h60 + i));
        a_en = 1;
        repeat (4) step();
        rdy_en = 0;
        step();
        held = in_data_o;
        chk("t4_stall_valid_c0", in_valid_o, 1'b1);
        chk("t4_stall_a_ready_c0", a_ready_o, 1'b0);
        for (int i = 1; i < 5; i++) begin
            step();
            chk($sformatf("t4_stall_data_c%0d", i), in_data_o, held);
            chk($sformatf("t4_stall_valid_c%0d", i), in_valid_o, 1'b1);
            chk($sformatf("t4_stall_a_ready_c%0d", i), a_ready_o, 1'b0);
        end
        rdy_en = 1;
        repeat (40) step();
        chk("t4_bytes_in", cnt_in, 10);
        chk("t4_out_eq_in", cnt_out, cnt_in);
        chk("t4_sb_drained", sb_q.size(), 0);

        // Test 5: A sends one byte then goes quiet while B waits.
        do_reset();
        a_src.push_back(8'h71);
        b_src.push_back(8'h81);
        a_en = 1; b_en = 1;
        repeat (30) step();
        chk("t5_release_seen", rel_seen, 1'b1);
        // Sample cycle precedes its accept edge by one, hence the +1.
        chk("t5_release_delay", rel_cyc - last_a_cyc, IDLE_MAX + 1);
        chk("t5_b_after_release", b_first_cyc - rel_cyc, 1);
        chk("t5_sb_drained", sb_q.size(), 0);

        // Test 6: one-cycle reset pulse mid-burst.
        do_reset();
        for (int i = 0; i < 6; i++) a_src.push_back(8'(8'h90 + i));
        a_en = 1;
        repeat (4) step();
        chk("t6_pre_reset_valid", in_valid_o, 1'b1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        a_src.delete(); b_src.delete(); sb_q.delete();
        a_src.push_back(8'hA5); b_src.push_back(8'hB5);
        a_en = 1; b_en = 1;
        a_valid_i = 1'b1; a_data_i = 8'hA5;
        b_valid_i = 1'b1; b_data_i = 8'hB5;
        #1;
        chk("t6_post_reset_valid", in_valid_o, 1'b0);
        chk("t6_post_reset_grant", grant_o, 2'b00);
        chk("t6_post_reset_data", in_data_o, 8'h00);
        step();
        chk("t6_first_grant_a", grant_o, 2'b01);
        repeat (40) step();
        chk("t6_sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
